spi_cmd_decoder: RTL and testbench
==================================

// Module: spi_cmd_decoder
// PURPOSE
//  Sits directly downstream of the SPI byte receiver, in the sysclk domain. Turns received bytes into
//  register writes and reads for the fan controller (PWM duty, mode, etc.).
//  Brings the receiver's byte-ready level and chip select into sysclk, then parses command frames.
//  Drives the tx byte and tx-ready back to the receiver for MISO replies.
// PARAMETERS
//  NREGS       4      number of 8-bit control registers (1..16)
//  SYNC_STAGES 2      synchronizer flops on rx-ready and CS (>=2)
//  REG_RESET   8'h80  reset value of every control register
// PORTS
//  sysclk      in   1        FPGA clock; sole clock of this block
//  reset       in   1        synchronous, active-high reset
//  iRxReady    in   1        receiver byte-ready level, SPI clock domain (async here)
//  iRx         in   8        receiver byte; stable from iRxReady rise until >=8 SPI clocks later
//  iSPICS      in   1        raw chip select, active-low, async
//  oTxReady    out  1        reply byte valid (level)
//  oTx         out  8        reply byte
//  oRegs       out  NREGS*8  control registers, reg k at [8k+7:8k]
//  oWrStrobe   out  1        one-cycle pulse when a register is written
//  oWrAddr     out  4        address of the write flagged by oWrStrobe
//  oErrCount   out  8        saturating count of aborted or illegal frames
// BEHAVIOUR
//  Reset: oRegs all REG_RESET, oTx=0, oTxReady=0, oWrStrobe=0, oWrAddr=0, oErrCount=0.
//   State=IDLE; synchronizer flops cleared. Reset applied mid-frame drops the frame silently, with no error count.
//  Sync: iRxReady and iSPICS each pass through SYNC_STAGES flops.
//   byteEv = rising edge of synced rx-ready. frameEnd = rising edge of synced CS.
//   On byteEv, iRx is captured into rxByte. sysclk must be >= 4x SPI clock.
//  Cmd byte: op = cmd[7:6], addr = cmd[3:0], cmd[5:4] ignored.
//   op 00=NOP, 01=WRITE, 10=READ, 11=illegal.
//  State machine, evaluated on byteEv:
//   IDLE, NOP                  -> stay IDLE.
//   IDLE, WRITE, addr<NREGS    -> WDATA; latch addr.
//   IDLE, READ,  addr<NREGS    -> IDLE. Next cycle oTx = reg[addr], oTxReady = 1.
//   IDLE, op 11 or addr>=NREGS -> ERR; oErrCount += 1.
//   WDATA, any byte            -> reg[addr] <= byte; IDLE.
//                                 oWrStrobe=1 and oWrAddr=addr on the following cycle.
//   ERR                        -> all bytes ignored until frameEnd.
//  frameEnd:
//   State -> IDLE; oTxReady -> 0 (oTx holds its value).
//   If state was WDATA, the write is dropped and oErrCount += 1.
//  byteEv and frameEnd in the same cycle:
//   The byte is processed first, then frameEnd is applied.
//   A data byte that arrives with frameEnd still completes its write.
//   A READ that arrives with frameEnd leaves oTxReady = 0.
//  oTxReady behaviour:
//   Held until frameEnd or the next byteEv.
//   A later READ in the same frame reloads oTx.
//   A non-READ byteEv clears oTxReady.
//  oErrCount saturates at 8'hFF and never wraps.
//  Write latency: last SCK edge to oRegs update = SYNC_STAGES+2 sysclk cycles.
// STRUCTURE
//  Shared header spi_cmd_defs.vh:
//   OP_NOP/OP_WRITE/OP_READ/OP_ILL localparams.
//   State encodings ST_IDLE/ST_WDATA/ST_ERR.
//   Field positions OP_MSB/OP_LSB/ADDR_MSB.
//  Sub-module sync_edge (param STAGES): synchronizer chain plus rising-edge pulse output.
//   Instantiated twice: once for rx-ready, once for CS.
//  Top level holds the FSM, the register file, the tx holding register and the error counter.
// TESTING
//  1 Reset asserted 3 cycles -> oRegs=all 8'h80, oTxReady=0, oErrCount=0, oWrStrobe=0.
//  2 CS low, bytes 0x41,0x7F, CS high -> reg1=0x7F; one oWrStrobe pulse with oWrAddr=1; other regs 0x80.
//  3 After test 2, CS low, byte 0x81 -> oTx=0x7F, oTxReady=1; CS high -> oTxReady=0.
//  4 CS low, 0x42, CS high (no data byte) -> reg2 stays 0x80; oErrCount=1; no strobe.
//  5 Byte 0x45 (addr 5, NREGS=4) then 0x01; CS high -> ERR path, no write, oErrCount=1.
//    Repeat with 0xC0 -> oErrCount=2.
//  6 Two further checks:
//    a) 300 aborted frames -> oErrCount=0xFF.
//    b) reset pulsed after 0x43 -> state IDLE; next 0x7F byte does not write reg3.

Source files
------------

// File: rtl/spi_cmd_decoder_pkg.sv
// spi_cmd_decoder_pkg: opcode, field-position and FSM-state definitions shared by the SPI command decoder
package spi_cmd_decoder_pkg;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 6;
  localparam int ADDR_MSB = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_ERR} state_t;
endpackage

// File: rtl/spi_cmd_decoder_sync_edge.sv
// sync_edge: STAGES-deep synchronizer with a one-cycle rising-edge pulse (sysclk, reset, din async in, rise out)
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic sysclk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic [STAGES-1:0] chain;
  logic prev;
  always_ff @(posedge sysclk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end
  assign rise = chain[STAGES-1] & ~prev;
endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses SPI command frames into control-register writes/reads (sysclk, reset, iRxReady/iRx/iSPICS in; oTxReady/oTx/oRegs/oWrStrobe/oWrAddr/oErrCount out)
module spi_cmd_decoder
  import spi_cmd_decoder_pkg::*;
#(
  parameter int         NREGS       = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REG_RESET   = 8'h80
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               iRxReady,
  input  logic [7:0]         iRx,
  input  logic               iSPICS,
  output logic               oTxReady,
  output logic [7:0]         oTx,
  output logic [NREGS*8-1:0] oRegs,
  output logic               oWrStrobe,
  output logic [3:0]         oWrAddr,
  output logic [7:0]         oErrCount
);
  logic byteEv, frameEnd;
  state_t state, byteState;
  logic [3:0] wrAddr, addr;
  logic [1:0] op;
  logic [7:0] rdByte;
  logic addrOk, idleByte, illegal, doRead, startWr, doWrite, errInc;
  sync_edge #(.STAGES(SYNC_STAGES)) rxSync (.sysclk(sysclk), .reset(reset), .din(iRxReady), .rise(byteEv));
  sync_edge #(.STAGES(SYNC_STAGES)) csSync (.sysclk(sysclk), .reset(reset), .din(iSPICS), .rise(frameEnd));
  // iRx is still stable when byteEv fires, so it is used directly as the captured byte
  always_comb begin
    op = iRx[OP_MSB:OP_LSB];
    addr = iRx[ADDR_MSB:0];
    addrOk = {1'b0, addr} < 5'(NREGS);
    idleByte = byteEv && state == ST_IDLE;
    illegal = op == OP_ILL || (op != OP_NOP && !addrOk);
    doRead = idleByte && op == OP_READ && addrOk;
    startWr = idleByte && op == OP_WRITE && addrOk;
    doWrite = byteEv && state == ST_WDATA;
    byteState = startWr ? ST_WDATA : (idleByte && illegal) ? ST_ERR : doWrite ? ST_IDLE : state;
    // the byte is applied before frameEnd, so a frame ending while still awaiting data is an abort
    errInc = (idleByte && illegal) || (frameEnd && byteState == ST_WDATA);
    rdByte = '0;
    for (int k = 0; k < NREGS; k++)
      if (addr == 4'(k)) rdByte = oRegs[8*k +: 8];
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= ST_IDLE;
      wrAddr <= '0;
      oRegs <= {NREGS{REG_RESET}};
      oTx <= '0;
      oTxReady <= 1'b0;
      oWrStrobe <= 1'b0;
      oWrAddr <= '0;
      oErrCount <= '0;
    end else begin
      state <= frameEnd ? ST_IDLE : byteState;
      if (startWr) wrAddr <= addr;
      for (int k = 0; k < NREGS; k++)
        if (doWrite && wrAddr == 4'(k)) oRegs[8*k +: 8] <= iRx;
      oWrStrobe <= doWrite;
      if (doWrite) oWrAddr <= wrAddr;
      if (doRead) oTx <= rdByte;
      oTxReady <= !frameEnd && (doRead || (oTxReady && !byteEv));
      if (errInc && oErrCount != 8'hFF) oErrCount <= oErrCount + 8'd1;
    end
  end
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: directed frames checked against a byte-level behavioural model plus literal expectations
module tb_spi_cmd_decoder;
  localparam int NREGS = 4;
  logic sysclk = 1'b0, reset = 1'b0, iRxReady = 1'b0, iSPICS = 1'b1;
  logic [7:0] iRx = '0;
  logic oTxReady, oWrStrobe;
  logic [7:0] oTx, oErrCount;
  logic [NREGS*8-1:0] oRegs;
  logic [3:0] oWrAddr;
  int nChk = 0, nPass = 0;
  bit settled = 0;
  int strobeCnt = 0, lastAddr = 0;
  int mRegs [NREGS];
  int mTx = 0, mErr = 0, mPend = -1, mWrCnt = 0, mLastAddr = 0;
  bit mTxReady = 0, mInErr = 0;

  spi_cmd_decoder #(.NREGS(NREGS), .SYNC_STAGES(2), .REG_RESET(8'h80)) dut (
    .sysclk(sysclk), .reset(reset), .iRxReady(iRxReady), .iRx(iRx), .iSPICS(iSPICS),
    .oTxReady(oTxReady), .oTx(oTx), .oRegs(oRegs), .oWrStrobe(oWrStrobe),
    .oWrAddr(oWrAddr), .oErrCount(oErrCount));

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] packRegs();
    logic [31:0] p = '0;
    for (int k = 0; k < NREGS; k++) p[8*k +: 8] = 8'(mRegs[k]);
    return p;
  endfunction

  task automatic modelErr();
    mErr = mErr < 255 ? mErr + 1 : 255;
  endtask

  task automatic modelReset();
    for (int k = 0; k < NREGS; k++) mRegs[k] = 8'h80;
    mTx = 0; mErr = 0; mPend = -1; mWrCnt = 0; mTxReady = 0; mInErr = 0;
  endtask

  task automatic modelByte(input logic [7:0] b);
    int op, a;
    op = int'(b[7:6]);
    a = int'(b[3:0]);
    mTxReady = 0;
    if (mInErr) ;
    else if (mPend >= 0) begin
      mRegs[mPend] = int'(b); mWrCnt++; mLastAddr = mPend; mPend = -1;
    end else if (op == 1 && a < NREGS) mPend = a;
    else if (op == 2 && a < NREGS) begin
      mTx = mRegs[a]; mTxReady = 1;
    end else if (op != 0) begin
      modelErr(); mInErr = 1;
    end
  endtask

  task automatic modelEnd();
    if (mPend >= 0) modelErr();
    mPend = -1; mInErr = 0; mTxReady = 0;
  endtask

  always @(negedge sysclk) begin
    if (reset) strobeCnt = 0;
    else if (oWrStrobe) begin
      strobeCnt++; lastAddr = int'(oWrAddr);
    end
  end

  always @(negedge sysclk) begin
    if (settled) begin
      chk("regs", oRegs, packRegs());
      chk("tx", {24'd0, oTx}, 32'(mTx));
      chk("txReady", {31'd0, oTxReady}, {31'd0, mTxReady});
      chk("errCount", {24'd0, oErrCount}, 32'(mErr));
      chk("strobeCount", 32'(strobeCnt), 32'(mWrCnt));
      if (mWrCnt > 0) chk("wrAddr", 32'(lastAddr), 32'(mLastAddr));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic doReset();
    settled = 0; reset = 1; step(3); reset = 0; modelReset(); step(6); settled = 1; step(2);
  endtask

  task automatic csLow();
    settled = 0; iSPICS = 0; step(4); settled = 1; step(1);
  endtask

  task automatic csHigh();
    settled = 0; iSPICS = 1; step(8); modelEnd(); settled = 1; step(2);
  endtask

  task automatic sendByte(input logic [7:0] b);
    settled = 0; iRx = b; iRxReady = 1; step(8); iRxReady = 0; step(8);
    modelByte(b); settled = 1; step(2);
  endtask

  task automatic byteAndEnd(input logic [7:0] b);
    settled = 0; iRx = b; iRxReady = 1; iSPICS = 1; step(8); iRxReady = 0; step(8);
    modelByte(b); modelEnd(); settled = 1; step(2);
  endtask

  initial begin
    step(2);
    doReset();
    chk("reset regs", oRegs, 32'h80808080);
    chk("reset txReady", {31'd0, oTxReady}, 32'd0);
    chk("reset err", {24'd0, oErrCount}, 32'd0);
    chk("reset strobe", {31'd0, oWrStrobe}, 32'd0);
    csLow(); sendByte(8'h41); sendByte(8'h7F); csHigh();
    chk("write reg1", oRegs, 32'h80807F80);
    chk("write strobes", 32'(strobeCnt), 32'd1);
    chk("write addr", 32'(lastAddr), 32'd1);
    csLow(); sendByte(8'h81);
    chk("read tx", {24'd0, oTx}, 32'h7F);
    chk("read txReady", {31'd0, oTxReady}, 32'd1);
    csHigh();
    chk("read end txReady", {31'd0, oTxReady}, 32'd0);
    chk("read end tx holds", {24'd0, oTx}, 32'h7F);
    csLow(); sendByte(8'h42); csHigh();
    chk("abort regs", oRegs, 32'h80807F80);
    chk("abort err", {24'd0, oErrCount}, 32'd1);
    chk("abort no strobe", 32'(strobeCnt), 32'd1);
    csLow(); sendByte(8'h43); byteAndEnd(8'h5A);
    chk("same-cycle write", oRegs, 32'h5A807F80);
    chk("same-cycle write err", {24'd0, oErrCount}, 32'd1);
    csLow(); byteAndEnd(8'h83);
    chk("same-cycle read txReady", {31'd0, oTxReady}, 32'd0);
    csLow(); sendByte(8'h81); sendByte(8'h83);
    chk("reread tx", {24'd0, oTx}, 32'h5A);
    sendByte(8'h00);
    chk("nop clears txReady", {31'd0, oTxReady}, 32'd0);
    csHigh();
    doReset();
    csLow(); sendByte(8'h45); sendByte(8'h01); csHigh();
    chk("bad addr err", {24'd0, oErrCount}, 32'd1);
    chk("bad addr regs", oRegs, 32'h80808080);
    chk("bad addr strobes", 32'(strobeCnt), 32'd0);
    csLow(); sendByte(8'hC0); csHigh();
    chk("illegal op err", {24'd0, oErrCount}, 32'd2);
    doReset();
    for (int i = 0; i < 300; i++) begin
      csLow(); sendByte(8'hC0); csHigh();
    end
    chk("err saturates", {24'd0, oErrCount}, 32'hFF);
    iSPICS = 0;
    doReset();
    sendByte(8'h43);
    doReset();
    sendByte(8'h7F);
    chk("reset drops write", oRegs, 32'h80808080);
    chk("reset drops strobe", 32'(strobeCnt), 32'd0);
    csHigh();
    settled = 0;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
